uart_rx_cfg: RTL and testbench
==============================

# uart_rx_cfg

Parametrised, oversampling UART receiver. It is the successor to the fixed 8N1 receiver in the UART project. It converts the asynchronous serial line into parallel words with configurable data width, parity and stop-bit count. Each received word is reported with a one-cycle valid strobe and parity, framing and break status, for consumption by the project's command/loopback logic.

## Interface
- CLK_HZ, 10_000_000, clock frequency of source_clk in Hz
- BAUD_RATE, 9600, line bit rate
- OVERSAMPLE, 16, ticks per bit; even, ≥8
- DATA_BITS, 8, data word width; legal 5..9
- PARITY, 0, 0 = none, 1 = even, 2 = odd
- STOP_BITS, 1, legal 1 or 2
- Derived: TICK_DIV = CLK_HZ/(BAUD_RATE*OVERSAMPLE), must be ≥1; F = 1 + DATA_BITS + (PARITY?1:0) + STOP_BITS bits per frame
- Illegal parameter values stop elaboration with $error.

Ports:
- source_clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- i_rx_serial  in  1  asynchronous serial line, idle high
- o_rx_valid  out  1  one-cycle strobe: the word and flags are valid
- o_rx_data  out  DATA_BITS  received word, LSB first on the line
- o_parity_err  out  1  parity mismatch on the last word (always 0 when PARITY=0)
- o_frame_err  out  1  a stop bit was sampled low
- o_break  out  1  break: all data bits, parity bit and first stop bit were low
- o_busy  out  1  high in any state other than IDLE

## Operation
- **Synchronizer.** i_rx_serial passes through a 2-FF synchronizer, reset value 1. All logic uses the synchronized value `rxs`.
- **Tick divider.** Free-running counter 0..TICK_DIV-1 that emits a tick on its terminal count. It is cleared in the cycle a start is detected.
- **Phase counter.** Counts 0..OVERSAMPLE-1 per bit and advances on each tick.
- **Sampling.** Each bit is sampled at phases OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1. The bit value is the 2-of-3 majority, decided at phase OVERSAMPLE/2+1.
- **States:**
  - IDLE: rxs=0 → clear divider, phase and bit index → START.
  - START: majority=1 → IDLE (false start, no strobe). Majority=0 → DATA at the phase wrap.
  - DATA: store the majority into o_rx_data[bit index]. After DATA_BITS bits → PARITY if PARITY≠0, else STOP.
  - PARITY: even parity checks XOR(data, pbit)=0; odd parity checks XOR(data, pbit)=1.
  - STOP: at the decision point of the last stop bit → DONE. With STOP_BITS=2 the first stop bit is sampled and checked, then the state waits one more bit. Either stop bit sampled low sets frame_err.
  - DONE: pulse o_rx_valid for one cycle and load the flags. Go to IDLE if rxs=1, else to WAIT_HIGH.
  - WAIT_HIGH: stay until rxs=1, then go to IDLE. This prevents a held-low line (break) from re-triggering.
- **Early resync.** The final stop bit ends at its decision point, not its end, so back-to-back frames with clock mismatch up to ±3% are received.
- **Output registers.** o_rx_data and the flags are registered. They are updated only in DONE and held until the next DONE. The data register may shift during reception; the bench samples it only on valid.
- **Flag rules.** o_break=1 implies o_frame_err=1. o_parity_err is evaluated even when a frame error occurs.

## Timing
- **Reset.** rst asynchronously forces state IDLE and synchronizer=1. All outputs go to 0: o_rx_valid, o_rx_data, o_parity_err, o_frame_err, o_break, o_busy. This applies mid-frame as well; the partial word is discarded.
- **Synchronizer latency.** A line edge is seen as rxs 2 cycles after it appears at the input.
- **Tick numbering.** Let T0 be the cycle in which IDLE sees rxs=0. Tick m occurs at T0 + m·TICK_DIV, for m ≥ 1. Bit b (start = 0), phase p is processed at tick m = b·OVERSAMPLE + p + 1.
- **Valid latency.** o_rx_valid is high exactly in cycle T0 + TICK_DIV·((F-1)·OVERSAMPLE + OVERSAMPLE/2 + 2) + 1.
- **o_busy.** Rises the cycle after T0 and falls the cycle after DONE, or after WAIT_HIGH exits.
- **Next frame.** A new start edge is accepted in the first IDLE cycle after DONE.

## Test plan
Bench parameters: CLK_HZ=1_600_000, BAUD_RATE=100_000, OVERSAMPLE=16, so TICK_DIV=1 and each bit is 16 clocks.

1. **8N1 word:** send 0xA5 → exactly one o_rx_valid at the formula cycle; o_rx_data=0xA5; all three flags 0. Repeat back-to-back with 0x00, 0xFF, then 0x3C at baud +3% → every word is correct.
2. **Even parity (PARITY=1):** send 0x07 with pbit=1 → parity_err=0. Send 0x07 with pbit=0 → parity_err=1, data=0x07. Run again with PARITY=2 → the expected results invert.
3. **Framing error:** send 0x55 with the stop bit low → frame_err=1, break=0, data=0x55. Release the line, then send 0x3C → clean word, flags 0.
4. **Glitches:**
   - 4-clock low pulse on an idle line → no strobe, o_busy returns to 0 within 11 cycles of T0.
   - Single-cycle spike at the mid-sample of data bit 3 → majority rejects it, word unchanged.
5. **Break:** hold the line low for 20 bit times → exactly one strobe with data=0, frame_err=1, break=1. No further strobe until the line goes high; the next frame 0x81 is received clean.
6. **Reset and config sweep:**
   - Assert rst during data bit 3 → all outputs are 0 in the same cycle and there is no strobe. Frame 0x81 after release is correct.
   - DATA_BITS=5 / STOP_BITS=2: send 0x1B → data=0x1B, and valid latency matches the formula with F=8.

Source files
------------

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: oversampling UART receiver.
// The data width, parity mode and stop-bit count are set by parameters.
//
// Ports:
//   source_clk   : system clock
//   rst          : asynchronous active-high reset
//   i_rx_serial  : asynchronous serial line, idles high
//   o_rx_valid   : one-cycle strobe; o_rx_data and the flags are valid
//   o_rx_data    : received word, sent LSB first on the line
//   o_parity_err : parity mismatch on the last word
//   o_frame_err  : a stop bit was sampled low
//   o_break      : all data bits, the parity bit and the first stop bit were low
//   o_busy       : receiver is in any state other than IDLE
module uart_rx_cfg #(
  parameter int CLK_HZ     = 10_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 source_clk,
  input  logic                 rst,
  input  logic                 i_rx_serial,
  output logic                 o_rx_valid,
  output logic [DATA_BITS-1:0] o_rx_data,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_break,
  output logic                 o_busy
);

  localparam int TICK_DIV = CLK_HZ / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int PH_W     = $clog2(OVERSAMPLE);
  localparam int BI_W     = $clog2(DATA_BITS);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [PH_W-1:0]  PH_A     = PH_W'(OVERSAMPLE / 2 - 1);
  localparam logic [PH_W-1:0]  PH_B     = PH_W'(OVERSAMPLE / 2);
  localparam logic [PH_W-1:0]  PH_DEC   = PH_W'(OVERSAMPLE / 2 + 1);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(OVERSAMPLE - 1);
  localparam logic [BI_W-1:0]  BI_LAST  = BI_W'(DATA_BITS - 1);

  generate
    if (TICK_DIV < 1) begin : g_err_div
      $error("uart_rx_cfg: CLK_HZ/(BAUD_RATE*OVERSAMPLE) must be >= 1");
    end
    if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_err_os
      $error("uart_rx_cfg: OVERSAMPLE must be even and >= 8");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_err_db
      $error("uart_rx_cfg: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_err_par
      $error("uart_rx_cfg: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_err_stop
      $error("uart_rx_cfg: STOP_BITS must be 1 or 2");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_DONE, S_WAIT_HIGH
  } state_t;

  // Two-stage synchronizer; it resets to the idle line level.
  logic sync_meta;
  logic rxs;

  always_ff @(posedge source_clk or posedge rst) begin
    if (rst) begin
      sync_meta <= 1'b1;
      rxs       <= 1'b1;
    end else begin
      sync_meta <= i_rx_serial;
      rxs       <= sync_meta;
    end
  end

  state_t               state;
  logic [DIV_W-1:0]     div_cnt;
  logic [PH_W-1:0]      phase;
  logic [BI_W-1:0]      bit_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] data_sr;
  logic                 s_a;
  logic                 s_b;
  logic                 par_err;
  logic                 frm_err;
  logic                 any_high;

  logic tick;
  logic in_bit;
  logic at_decide;
  logic at_wrap;
  logic maj;
  logic par_bad;

  assign tick      = (div_cnt == DIV_LAST);
  assign in_bit    = (state == S_START) || (state == S_DATA) ||
                     (state == S_PARITY) || (state == S_STOP);
  assign at_decide = tick && (phase == PH_DEC);
  assign at_wrap   = tick && (phase == PH_LAST);
  // The third sample is the live synchronized value at the decision phase.
  assign maj       = (s_a & s_b) | (s_a & rxs) | (s_b & rxs);
  // Even parity wants an XOR of 0 over data and parity bit; odd wants 1.
  assign par_bad   = (PARITY == 2) ? ~(^data_sr ^ maj) : (^data_sr ^ maj);

  always_ff @(posedge source_clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      div_cnt      <= '0;
      phase        <= '0;
      bit_idx      <= '0;
      stop_idx     <= 1'b0;
      data_sr      <= '0;
      s_a          <= 1'b1;
      s_b          <= 1'b1;
      par_err      <= 1'b0;
      frm_err      <= 1'b0;
      any_high     <= 1'b0;
      o_rx_valid   <= 1'b0;
      o_rx_data    <= '0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
      o_break      <= 1'b0;
      o_busy       <= 1'b0;
    end else begin
      o_rx_valid <= 1'b0;

      // Free-running divider, realigned to the start edge.
      if ((state == S_IDLE && !rxs) || tick) begin
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end

      if (tick && in_bit) begin
        phase <= (phase == PH_LAST) ? '0 : phase + 1'b1;
        if (phase == PH_A) s_a <= rxs;
        if (phase == PH_B) s_b <= rxs;
      end

      case (state)
        S_IDLE: begin
          if (!rxs) begin
            phase    <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            par_err  <= 1'b0;
            frm_err  <= 1'b0;
            any_high <= 1'b0;
            o_busy   <= 1'b1;
            state    <= S_START;
          end
        end

        S_START: begin
          if (at_decide && maj) begin
            // False start: the low level did not last to mid-bit.
            state  <= S_IDLE;
            o_busy <= 1'b0;
          end else if (at_wrap) begin
            state <= S_DATA;
          end
        end

        S_DATA: begin
          if (at_decide) begin
            data_sr[bit_idx] <= maj;
            any_high         <= any_high | maj;
          end
          if (at_wrap) begin
            if (bit_idx == BI_LAST) begin
              state <= (PARITY != 0) ? S_PARITY : S_STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end

        S_PARITY: begin
          if (at_decide) begin
            par_err  <= par_bad;
            any_high <= any_high | maj;
          end
          if (at_wrap) state <= S_STOP;
        end

        S_STOP: begin
          if (at_decide) begin
            if (stop_idx == 1'(STOP_BITS - 1)) begin
              // The frame ends at the last stop bit's decision point, which
              // leaves half a bit of slack for the next start edge.
              state        <= S_DONE;
              o_rx_valid   <= 1'b1;
              o_rx_data    <= data_sr;
              o_parity_err <= par_err;
              o_frame_err  <= frm_err | ~maj;
              // Only the first stop bit takes part in break detection.
              o_break      <= (stop_idx == 1'b0) ? ~(any_high | maj) : ~any_high;
            end else begin
              frm_err  <= frm_err | ~maj;
              any_high <= any_high | maj;
            end
          end
          if (at_wrap) stop_idx <= 1'b1;
        end

        S_DONE: begin
          if (rxs) begin
            state  <= S_IDLE;
            o_busy <= 1'b0;
          end else begin
            state <= S_WAIT_HIGH;
          end
        end

        S_WAIT_HIGH: begin
          // A held-low line (break) must go high before a new start can arm.
          if (rxs) begin
            state  <= S_IDLE;
            o_busy <= 1'b0;
          end
        end

        default: begin
          state  <= S_IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
module tb_uart_rx_cfg;

  localparam int TICK_DIV = 1_600_000 / (100_000 * 16);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [3:0] rx_line;
  logic [3:0] v, pe, fe, brk, busy;
  logic [7:0] d0, d1, d2;
  logic [4:0] d3;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // dut 0: 8N1, dut 1: 8E1, dut 2: 8O1, dut 3: 5N2
  uart_rx_cfg #(.CLK_HZ(1_600_000), .BAUD_RATE(100_000), .OVERSAMPLE(16),
                .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut0 (
    .source_clk(clk), .rst(rst), .i_rx_serial(rx_line[0]), .o_rx_valid(v[0]),
    .o_rx_data(d0), .o_parity_err(pe[0]), .o_frame_err(fe[0]), .o_break(brk[0]),
    .o_busy(busy[0]));
  uart_rx_cfg #(.CLK_HZ(1_600_000), .BAUD_RATE(100_000), .OVERSAMPLE(16),
                .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) dut1 (
    .source_clk(clk), .rst(rst), .i_rx_serial(rx_line[1]), .o_rx_valid(v[1]),
    .o_rx_data(d1), .o_parity_err(pe[1]), .o_frame_err(fe[1]), .o_break(brk[1]),
    .o_busy(busy[1]));
  uart_rx_cfg #(.CLK_HZ(1_600_000), .BAUD_RATE(100_000), .OVERSAMPLE(16),
                .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut2 (
    .source_clk(clk), .rst(rst), .i_rx_serial(rx_line[2]), .o_rx_valid(v[2]),
    .o_rx_data(d2), .o_parity_err(pe[2]), .o_frame_err(fe[2]), .o_break(brk[2]),
    .o_busy(busy[2]));
  uart_rx_cfg #(.CLK_HZ(1_600_000), .BAUD_RATE(100_000), .OVERSAMPLE(16),
                .DATA_BITS(5), .PARITY(0), .STOP_BITS(2)) dut3 (
    .source_clk(clk), .rst(rst), .i_rx_serial(rx_line[3]), .o_rx_valid(v[3]),
    .o_rx_data(d3), .o_parity_err(pe[3]), .o_frame_err(fe[3]), .o_break(brk[3]),
    .o_busy(busy[3]));

  typedef struct {
    int         dut;
    logic [8:0] data;
    logic       pe;
    logic       fe;
    logic       brk;
    int         cyc;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;

  function automatic logic [8:0] dut_data(input int d);
    case (d)
      0: return {1'b0, d0};
      1: return {1'b0, d1};
      2: return {1'b0, d2};
      default: return {4'b0, d3};
    endcase
  endfunction

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cyc %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    for (int d = 0; d < 4; d++) begin
      if (v[d]) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe: dut%0d data=0x%0h at cyc %0d, required no strobe",
                   d, dut_data(d), cyc);
        end else begin
          mon_e = sbq.pop_front();
          check("strobe_dut", d, mon_e.dut);
          check("rx_data", int'(dut_data(d)), int'(mon_e.data));
          check("parity_err", int'(pe[d]), int'(mon_e.pe));
          check("frame_err", int'(fe[d]), int'(mon_e.fe));
          check("break", int'(brk[d]), int'(mon_e.brk));
          check("valid_cycle", cyc, mon_e.cyc);
          $display("frame dut%0d data=0x%0h pe=%0b fe=%0b brk=%0b cyc=%0d",
                   d, dut_data(d), pe[d], fe[d], brk[d], cyc);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Expected strobe: 2 cycles of synchronizer, then the valid-latency formula.
  task automatic expect_frame(input int d, input logic [8:0] data, input logic e_pe,
                              input logic e_fe, input logic e_brk, input int f);
    exp_t e;
    e.dut  = d;
    e.data = data;
    e.pe   = e_pe;
    e.fe   = e_fe;
    e.brk  = e_brk;
    e.cyc  = cyc + 2 + TICK_DIV * ((f - 1) * 16 + 16 / 2 + 2) + 1;
    sbq.push_back(e);
  endtask

  // pbit < 0: no parity bit. speed is the line rate in percent of nominal.
  // glitch: frame-relative cycle that gets inverted, or -1.
  task automatic send_frame(input int d, input logic [8:0] data, input int nbits,
                            input int pbit, input int nstop, input logic stop_val,
                            input int speed, input int glitch);
    logic [15:0] fr;
    int          nb;
    int          cnt;
    int          len;
    logic        val;
    fr  = '1;
    nb  = 0;
    cnt = 0;
    fr[nb] = 1'b0;
    nb++;
    for (int i = 0; i < nbits; i++) begin
      fr[nb] = data[i];
      nb++;
    end
    if (pbit >= 0) begin
      fr[nb] = pbit[0];
      nb++;
    end
    fr[nb] = stop_val;
    nb++;
    if (nstop == 2) begin
      fr[nb] = 1'b1;
      nb++;
    end
    for (int b = 0; b < nb; b++) begin
      len = ((b + 1) * 1600) / speed - (b * 1600) / speed;
      for (int c = 0; c < len; c++) begin
        val = fr[b];
        if (cnt == glitch) val = ~val;
        rx_line[d] = val;
        step(1);
        cnt++;
      end
    end
    rx_line[d] = 1'b1;
  endtask

  task automatic check_all_zero(input string name);
    for (int d = 0; d < 4; d++) begin
      check(name, int'({v[d], pe[d], fe[d], brk[d], busy[d], dut_data(d)}), 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst     = 1'b1;
    rx_line = 4'hF;
    step(5);
    check_all_zero("reset_outputs");
    rst = 1'b0;
    step(10);

    // 8N1 back-to-back, the last word 3% fast.
    expect_frame(0, 9'h0A5, 1'b0, 1'b0, 1'b0, 10);
    send_frame(0, 9'h0A5, 8, -1, 1, 1'b1, 100, -1);
    expect_frame(0, 9'h000, 1'b0, 1'b0, 1'b0, 10);
    send_frame(0, 9'h000, 8, -1, 1, 1'b1, 100, -1);
    expect_frame(0, 9'h0FF, 1'b0, 1'b0, 1'b0, 10);
    send_frame(0, 9'h0FF, 8, -1, 1, 1'b1, 100, -1);
    expect_frame(0, 9'h03C, 1'b0, 1'b0, 1'b0, 10);
    send_frame(0, 9'h03C, 8, -1, 1, 1'b1, 103, -1);
    step(40);

    // Even parity: 0x07 has three ones.
    expect_frame(1, 9'h007, 1'b0, 1'b0, 1'b0, 11);
    send_frame(1, 9'h007, 8, 1, 1, 1'b1, 100, -1);
    step(20);
    expect_frame(1, 9'h007, 1'b1, 1'b0, 1'b0, 11);
    send_frame(1, 9'h007, 8, 0, 1, 1'b1, 100, -1);
    step(20);
    // Odd parity: same frames, inverted verdict.
    expect_frame(2, 9'h007, 1'b1, 1'b0, 1'b0, 11);
    send_frame(2, 9'h007, 8, 1, 1, 1'b1, 100, -1);
    step(20);
    expect_frame(2, 9'h007, 1'b0, 1'b0, 1'b0, 11);
    send_frame(2, 9'h007, 8, 0, 1, 1'b1, 100, -1);
    step(20);

    // Framing error, then a clean word.
    expect_frame(0, 9'h055, 1'b0, 1'b1, 1'b0, 10);
    send_frame(0, 9'h055, 8, -1, 1, 1'b0, 100, -1);
    step(20);
    expect_frame(0, 9'h03C, 1'b0, 1'b0, 1'b0, 10);
    send_frame(0, 9'h03C, 8, -1, 1, 1'b1, 100, -1);
    step(20);

    // 4-cycle low pulse: false start, no strobe.
    rx_line[0] = 1'b0;
    step(4);
    rx_line[0] = 1'b1;
    step(1);
    check("glitch_busy_high", int'(busy[0]), 1);
    step(8);
    check("glitch_busy_low", int'(busy[0]), 0);
    step(20);

    // Single-cycle spike on the middle sample of data bit 3 (frame bit 4).
    expect_frame(0, 9'h0A5, 1'b0, 1'b0, 1'b0, 10);
    send_frame(0, 9'h0A5, 8, -1, 1, 1'b1, 100, 4 * 16 + 9);
    step(20);

    // Break: line low for 20 bit times.
    expect_frame(0, 9'h000, 1'b0, 1'b1, 1'b1, 10);
    rx_line[0] = 1'b0;
    step(320);
    check("break_busy_held", int'(busy[0]), 1);
    rx_line[0] = 1'b1;
    step(20);
    check("break_busy_released", int'(busy[0]), 0);
    expect_frame(0, 9'h081, 1'b0, 1'b0, 1'b0, 10);
    send_frame(0, 9'h081, 8, -1, 1, 1'b1, 100, -1);
    step(20);

    // Reset in the middle of data bit 3 of 0x81.
    rx_line[0] = 1'b0;
    step(16);
    rx_line[0] = 1'b1;
    step(16);
    rx_line[0] = 1'b0;
    step(40);
    check("busy_before_reset", int'(busy[0]), 1);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("async_reset_outputs");
    rx_line[0] = 1'b1;
    step(3);
    rst = 1'b0;
    step(40);
    expect_frame(0, 9'h081, 1'b0, 1'b0, 1'b0, 10);
    send_frame(0, 9'h081, 8, -1, 1, 1'b1, 100, -1);
    step(20);

    // 5 data bits, 2 stop bits: F = 8.
    expect_frame(3, 9'h01B, 1'b0, 1'b0, 1'b0, 8);
    send_frame(3, 9'h01B, 5, -1, 2, 1'b1, 100, -1);

    for (int i = 0; i < 500 && sbq.size() != 0; i++) step(1);
    check("scoreboard_drained", sbq.size(), 0);
    step(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
